// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory port arbiter: FSM states and master ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CAPT  = 2'd3
    } state_e;

    localparam logic M_IF = 1'b0;
    localparam logic M_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0] is the fetch master, req[1] the data master.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       last
);

    // On a tie the master that did not win last time goes first.
    always_comb begin
        // NOTE: defaulting every combinational output first guarantees no latch is inferred.
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == M_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset value M_D makes the fetch master win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= M_D;
        end else if (advance && (gnt != 2'b00)) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store front end for a single-port synchronous memory with a
// one-cycle registered read; one access in flight, round-robin between masters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    state_e     state, state_next;
    logic       owner;
    logic [1:0] arb_gnt;
    logic       arb_last;
    logic       idle;
    logic       grant_any;
    logic       winner;

    assign idle      = (state == IDLE);
    assign grant_any = idle && (if_req || d_req);
    assign winner    = arb_gnt[1];

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({d_req, if_req}),
        .advance (idle),
        .gnt     (arb_gnt),
        .last    (arb_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // mem_wre still holds the in-flight access type while in ISSUE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_any) state_next = ISSUE;
            ISSUE:   state_next = mem_wre ? IDLE : WAIT;
            WAIT:    state_next = CAPT;
            CAPT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = grant_any && !winner;
        d_gnt     = grant_any &&  winner;
        if_rvalid = (state == CAPT) && (owner == M_IF);
        d_rvalid  = (state == CAPT) && (owner == M_D);
        busy      = !idle;
    end

    // Memory strobes are registered from the winner; they drop on the cycle after issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ce   <= 1'b0;
            mem_wre  <= 1'b0;
            mem_ad   <= '0;
            mem_din  <= '0;
            owner    <= M_IF;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            mem_ce  <= grant_any;
            mem_wre <= grant_any && winner && d_we;
            if (grant_any) begin
                owner   <= winner;
                mem_ad  <= winner ? d_addr  : if_addr;
                mem_din <= winner ? d_wdata : '0;
            end
            if (state == WAIT) begin
                if (owner == M_D) d_rdata  <= mem_dout;
                else              if_rdata <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [7:0]  if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_ce, mem_wre;
    logic [7:0]  mem_ad;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        busy;

    logic [31:0] mem [256];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int if_rv_cnt = 0;
    int d_rv_cnt = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_ad(mem_ad),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0]  = 32'h0280_2483;
        mem[40] = 32'h0000_0006;
        mem[44] = 32'h0000_0005;
        mem_dout = '0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ce) begin
            if (mem_wre) mem[mem_ad] <= mem_din;
            else         mem_dout    <= mem[mem_ad];
        end
    end

    always @(negedge clk) begin
        if ((if_gnt || d_gnt) && (if_rvalid || d_rvalid)) overlap_cnt++;
        if (if_gnt && d_gnt) overlap_cnt++;
        if (if_rvalid) if_rv_cnt++;
        if (d_rvalid)  d_rv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access from one master; returns grant cycle, rvalid cycle (-1 if none) and data.
    task automatic access(input bit is_d, input bit we, input logic [7:0] addr,
                          input logic [31:0] wdata, output int gcyc, output int vcyc,
                          output logic [31:0] rd);
        gcyc = -1; vcyc = -1; rd = 'x;
        @(posedge clk); #1;
        if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else      begin if_req = 1'b1; if_addr = addr; end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (is_d ? d_gnt : if_gnt) begin gcyc = cyc; break; end
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        if (!we) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (is_d ? d_rvalid : if_rvalid) begin
                    vcyc = cyc; rd = is_d ? d_rdata : if_rdata; break;
                end
            end
        end
    endtask

    int g0, v0, g1, v1, cnt_if, cnt_d, bad;
    logic [31:0] r0, r1;
    int gnt_port [$];
    int rv_port [$];
    logic [31:0] rv_data [$];
    int gnt_cyc [$];

    initial begin
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_ce", 32'(mem_ce), 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        @(negedge clk); @(negedge clk); rst = 1'b1;

        // Fetch only
        cnt_d = d_rv_cnt;
        access(1'b0, 1'b0, 8'd0, '0, g0, v0, r0);
        check("fetch_gnt_seen", 32'(g0 >= 0), 1);
        check("fetch_latency", 32'(v0 - g0), 3);
        check("fetch_rdata", r0, 32'h0280_2483);
        repeat (3) @(negedge clk);
        check("fetch_no_d_rvalid", 32'(d_rv_cnt - cnt_d), 0);

        // Load, fetch data must stay put
        access(1'b1, 1'b0, 8'd40, '0, g0, v0, r0);
        check("load_latency", 32'(v0 - g0), 3);
        check("load_rdata", r0, 32'h6);
        check("load_if_rdata_kept", if_rdata, 32'h0280_2483);

        // Store then load at 44
        access(1'b1, 1'b1, 8'd44, 32'hDEAD_BEEF, g0, v0, r0);
        access(1'b1, 1'b0, 8'd44, '0, g1, v1, r1);
        check("store_gnt_spacing", 32'(g1 - g0), 2);
        check("store_load_rdata", r1, 32'hDEAD_BEEF);
        check("store_load_latency", 32'(v1 - g1), 3);

        // Contention from reset
        @(negedge clk); rst = 1'b0;
        if_req = 1'b1; if_addr = 8'd0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'd40;
        @(posedge clk); #1; rst = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (if_gnt) begin gnt_port.push_back(0); gnt_cyc.push_back(cyc); end
            if (d_gnt)  begin gnt_port.push_back(1); gnt_cyc.push_back(cyc); end
            if (if_rvalid) begin rv_port.push_back(0); rv_data.push_back(if_rdata); end
            if (d_rvalid)  begin rv_port.push_back(1); rv_data.push_back(d_rdata); end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("cont_gnt_count", 32'(gnt_port.size() >= 4), 1);
        check("cont_rv_count", 32'(rv_port.size() >= 4), 1);
        if (gnt_port.size() >= 4 && rv_port.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("cont_gnt%0d", i), 32'(gnt_port[i]), 32'(i % 2));
                check($sformatf("cont_rv%0d", i), 32'(rv_port[i]), 32'(i % 2));
                check($sformatf("cont_data%0d", i), rv_data[i],
                      (i % 2 == 0) ? 32'h0280_2483 : 32'h6);
            end
            check("cont_gnt_spacing", 32'(gnt_cyc[1] - gnt_cyc[0]), 4);
        end
        repeat (6) @(negedge clk);

        // Reset in the WAIT cycle of a fetch
        @(posedge clk); #1; if_req = 1'b1; if_addr = 8'd0;
        g0 = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_gnt) begin g0 = cyc; break; end
        end
        check("mid_rst_gnt_seen", 32'(g0 >= 0), 1);
        @(posedge clk); #1; if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_strobes", {29'd0, mem_ce, mem_wre, if_rvalid | d_rvalid}, 0);
        check("mid_rst_bus", 32'(mem_ad) | mem_din, 0);
        check("mid_rst_rdata", if_rdata | d_rdata, 0);
        cnt_if = if_rv_cnt; cnt_d = d_rv_cnt;
        @(negedge clk); rst = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_rvalid", 32'((if_rv_cnt - cnt_if) + (d_rv_cnt - cnt_d)), 0);
        access(1'b1, 1'b0, 8'd40, '0, g0, v0, r0);
        check("after_rst_load", r0, 32'h6);
        check("after_rst_latency", 32'(v0 - g0), 3);

        // Idle
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_ce || busy) bad++;
        end
        check("idle_quiet", 32'(bad), 0);
        check("no_gnt_rvalid_overlap", 32'(overlap_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
